// File: rtl/regfile_pkg.sv
// Shared widths and types for the write-back register file and its pending-write scoreboard.
package regfile_pkg;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam int NREGS = 1 << AW;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;

  localparam reg_idx_t          REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
endpackage

// File: rtl/sb_counter.sv
// One saturating up/down counter tracking writes in flight to a single register.
module sb_counter
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  // Simultaneous inc and dec cancel, so they never flag an error.
  assign ovf = inc & ~dec & (cnt == CNT_MAX);
  assign unf = dec & ~inc & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !ovf) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && !unf) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wb_regfile_sb.sv
// Write-back register file with per-register pending-write scoreboard and ID stall.
// Define WB_BYPASS_EN for write-first bypass of the retiring write into ID reads.
module wb_regfile_sb
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wb_memtoreg,
  input  logic     wb_regwrite,
  input  word_t    wb_dm_rdata,
  input  word_t    wb_alu_result,
  input  reg_idx_t wb_waddr,
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  output word_t    id_rdata1,
  output word_t    id_rdata2,
  input  logic     id_issue,
  input  logic     id_dest_we,
  input  reg_idx_t id_dest,
  output logic     stall,
  output logic     sb_err
);

  word_t                         regFile [NREGS];
  word_t                         wdata;
  logic                          wbWe;
  logic                          issueOk;
  logic [NREGS-1:1]              incVec, decVec, ovfVec, unfVec;
  logic [NREGS-1:0]              busyVec;
  logic [NREGS-1:1][CNT_W-1:0]   cnt;

  assign wdata = wb_memtoreg ? wb_dm_rdata : wb_alu_result;
  assign wbWe  = wb_regwrite & (wb_waddr != REG_ZERO);

  // id_issue is the valid and ~stall the ready: an instruction enters EX
  // (and claims its destination) only on a cycle where both are high.
  assign issueOk = id_issue & ~stall & id_dest_we;

  assign busyVec[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_sb
    assign incVec[g] = issueOk & (id_dest == reg_idx_t'(g));
    assign decVec[g] = wb_regwrite & (wb_waddr == reg_idx_t'(g));

    sb_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (incVec[g]),
      .dec   (decVec[g]),
      .cnt   (cnt[g]),
      .ovf   (ovfVec[g]),
      .unf   (unfVec[g])
    );

`ifdef WB_BYPASS_EN
    // The write retiring this cycle is already visible through the bypass.
    assign busyVec[g] = (cnt[g] - CNT_W'(decVec[g])) != '0;
`else
    assign busyVec[g] = cnt[g] != '0;
`endif
  end

  assign stall = busyVec[id_rs] | busyVec[id_rt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
    end else if (wbWe) begin
      regFile[wb_waddr] <= wdata;
    end
  end

  always_comb begin
    id_rdata1 = regFile[id_rs];
    id_rdata2 = regFile[id_rt];
`ifdef WB_BYPASS_EN
    if (wbWe && (wb_waddr == id_rs)) id_rdata1 = wdata;
    if (wbWe && (wb_waddr == id_rt)) id_rdata2 = wdata;
`endif
    if (id_rs == REG_ZERO) id_rdata1 = '0;
    if (id_rt == REG_ZERO) id_rdata2 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if ((|ovfVec) || (|unfVec)) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Self-checking bench for wb_regfile_sb: directed table, corner sequences and random traffic vs a model.
module tb_wb_regfile_sb;
  import regfile_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_memtoreg = 1'b0, wb_regwrite = 1'b0;
  logic [31:0] wb_dm_rdata = '0, wb_alu_result = '0;
  logic [4:0]  wb_waddr = '0, id_rs = '0, id_rt = '0, id_dest = '0;
  logic        id_issue = 1'b0, id_dest_we = 1'b0;
  logic [31:0] id_rdata1, id_rdata2;
  logic        stall, sb_err;

  int checks = 0;
  int failures = 0;

  // clock/reset block
  always #5 clk = ~clk;

  wb_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .wb_dm_rdata(wb_dm_rdata), .wb_alu_result(wb_alu_result), .wb_waddr(wb_waddr),
    .id_rs(id_rs), .id_rt(id_rt), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_issue(id_issue), .id_dest_we(id_dest_we), .id_dest(id_dest),
    .stall(stall), .sb_err(sb_err)
  );

  // reference model: writes in flight per register, architectural values, sticky error
  int          m_cnt [32];
  logic [31:0] m_reg [32];
  bit          m_err;
  bit          m_stall;

  function automatic logic [31:0] m_wdata();
    return wb_memtoreg ? wb_dm_rdata : wb_alu_result;
  endfunction

  function automatic bit m_busy(int r);
    int d;
    if (r == 0) return 1'b0;
    d = (wb_regwrite && wb_waddr == r) ? 1 : 0;
    return BYP ? ((m_cnt[r] - d) != 0) : (m_cnt[r] != 0);
  endfunction

  function automatic logic [31:0] m_read(int r);
    if (r == 0) return 32'h0;
    if (BYP && wb_regwrite && wb_waddr == r) return m_wdata();
    return m_reg[r];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_reg[i] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs at negedge, check model outputs before the edge
  task automatic drive(bit we, bit m2r, int wa, logic [31:0] dm, logic [31:0] alu,
                       int rs, int rt, bit iss, bit dwe, int dest);
    @(negedge clk);
    wb_regwrite = we; wb_memtoreg = m2r; wb_waddr = 5'(wa);
    wb_dm_rdata = dm; wb_alu_result = alu;
    id_rs = 5'(rs); id_rt = 5'(rt);
    id_issue = iss; id_dest_we = dwe; id_dest = 5'(dest);
    #1;
    m_stall = m_busy(rs) | m_busy(rt);
    chk("model_stall", 32'(stall), 32'(m_stall));
    chk("model_rdata1", id_rdata1, m_read(rs));
    chk("model_rdata2", id_rdata2, m_read(rt));
    chk("model_sb_err", 32'(sb_err), 32'(m_err));
  endtask

  task automatic idle(int rs, int rt);
    drive(0, 0, 0, 0, 0, rs, rt, 0, 0, 0);
  endtask

  // rising edge: update the model from the inputs that were presented
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = id_issue && !m_stall && id_dest_we && (id_dest != 0);
    for (int r = 1; r < 32; r++) begin
      bit inc, dec;
      inc = acc && (id_dest == r);
      dec = wb_regwrite && (wb_waddr == r);
      if (inc && !dec) begin
        if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
      end
    end
    if (wb_regwrite && wb_waddr != 0) m_reg[wb_waddr] = m_wdata();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_regwrite = 0; wb_memtoreg = 0; wb_waddr = 0; wb_dm_rdata = 0; wb_alu_result = 0;
    id_rs = 0; id_rt = 0; id_issue = 0; id_dest_we = 0; id_dest = 0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          we;
    bit          m2r;
    int          waddr;
    logic [31:0] dm;
    logic [31:0] alu;
    int          rs;
    int          rt;
    bit          iss;
    bit          dwe;
    int          dest;
    bit          e_stall;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{0, 0, 0, 0, 0,                       0, 0, 1, 1, 5, 0, 32'h0};
    vt[1] = '{0, 0, 0, 0, 0,                       5, 0, 0, 0, 0, 1, 32'h0};
    vt[2] = '{1, 0, 5, 32'h55, 32'h1234,           5, 0, 0, 0, 0, !BYP, BYP ? 32'h1234 : 32'h0};
    vt[3] = '{0, 0, 0, 0, 0,                       5, 0, 0, 0, 0, 0, 32'h1234};
    vt[4] = '{1, 1, 9, 32'hDEADBEEF, 32'h1,        0, 0, 0, 0, 0, 0, 32'h0};
    vt[5] = '{0, 0, 0, 0, 0,                       9, 5, 0, 0, 0, 0, 32'hDEADBEEF};
    vt[6] = '{1, 0, 0, 0, 32'hFFFFFFFF,            0, 0, 0, 0, 0, 0, 32'h0};
    vt[7] = '{0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 32'h0};

    m_reset();
    #12;
    rst_n = 1'b1;

    // reset state: every register reads 0, no stall, no error
    for (int i = 0; i < 32; i++) begin
      idle(i, 31 - i);
      chk("reset_rdata1", id_rdata1, 32'h0);
      chk("reset_stall", 32'(stall), 32'h0);
      tick();
    end
    chk("reset_sb_err", 32'(sb_err), 32'h0);

    // directed table: dependency stall on r5, memtoreg select, r0 write discard
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].we, vt[i].m2r, vt[i].waddr, vt[i].dm, vt[i].alu,
            vt[i].rs, vt[i].rt, vt[i].iss, vt[i].dwe, vt[i].dest);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d_rdata1", i), id_rdata1, vt[i].e_rd1);
      tick();
    end

    // three issues to r7, a fourth at saturation, then three retirements
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
      tick();
    end
    idle(7, 0);
    chk("r7_busy_at3", 32'(stall), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
    tick();
    idle(0, 0);
    chk("r7_overflow_err", 32'(sb_err), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 7, 0, 32'h70 + i, 7, 0, 0, 0, 0);
      chk($sformatf("r7_retire%0d_stall", i), 32'(stall), (i == 2 && BYP) ? 32'h0 : 32'h1);
      tick();
    end
    idle(0, 7);
    chk("r7_drained_stall", 32'(stall), 32'h0);
    chk("r7_value", id_rdata2, 32'h72);
    tick();

    // issue to r3 on the same edge that r3 retires: count stays at 1
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    tick();
    drive(1, 0, 3, 0, 32'h33, 0, 0, 1, 1, 3);
    tick();
    idle(3, 0);
    chk("r3_still_busy", 32'(stall), 32'h1);
    chk("r3_no_err", 32'(sb_err), 32'h0);
    tick();
    drive(1, 0, 3, 0, 32'h34, 0, 0, 0, 0, 0);
    tick();
    idle(0, 3);
    chk("r3_clear", 32'(stall), 32'h0);
    tick();

    // asynchronous reset while r4 has two writes in flight
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
    tick();
    drive(1, 0, 4, 0, 32'hAAAA, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
      tick();
    end
    idle(4, 0);
    chk("r4_busy", 32'(stall), 32'h1);
    chk("r4_value", id_rdata1, 32'hAAAA);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_stall", 32'(stall), 32'h0);
    chk("async_rst_r4", id_rdata1, 32'h0);
    chk("async_rst_err", 32'(sb_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      int wa, dest;
      bit we;
      wa   = $urandom_range(0, 7);
      we   = ($urandom_range(0, 2) == 0) && (m_cnt[wa] > 0 || $urandom_range(0, 15) == 0);
      dest = $urandom_range(0, 7);
      drive(we, 1'($urandom_range(0, 1)), wa, $urandom, $urandom,
            $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), dest);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
